// File: rtl/gpu_if_pkg.sv
// Shared GPU instruction-interface definitions: word widths, the packed
// two-word instruction type, and opcode field positions within the low word.
package gpu_if_pkg;
  localparam int WORD_W  = 32;
  localparam int INSTR_W = 2 * WORD_W;

  typedef struct packed {
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] a;
  } instr_t;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 8;

  localparam logic [OPC_W-1:0] OPC_NOP    = 8'h00;
  localparam logic [OPC_W-1:0] OPC_DRAW   = 8'h11;
  localparam logic [OPC_W-1:0] OPC_BLIT   = 8'h12;
  localparam logic [OPC_W-1:0] OPC_SETREG = 8'h20;
endpackage

// File: rtl/gpu_instr_fifo_mem.sv
// Instruction storage: one write port plus a registered read port that can
// alternatively capture the incoming word directly when the array is empty.
module gpu_instr_fifo_mem
  import gpu_if_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  instr_t           wdata,
  input  logic             re,
  input  logic [PTR_W-1:0] raddr,
  input  logic             byp,
  input  instr_t           byp_data,
  output instr_t           rdata
);

  instr_t mem [DEPTH];
  instr_t rdata_q, rdata_d;

  // Storage array carries no reset; only the read register is cleared.
  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (byp)     rdata_d = byp_data;
    else if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gpu_instr_fifo_rx.sv
// PIO instruction receiver: edge-detects wrreg, queues {data_b,data_a} in a
// FWFT FIFO whose head lives in the read register, flags almost-full/overflow.
module gpu_instr_fifo_rx
  import gpu_if_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [WORD_W-1:0]        data_a,
  input  logic [WORD_W-1:0]        data_b,
  input  logic                     wrreg,
  output logic                     wrfull,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [WORD_W-1:0]        instr_a,
  output logic [WORD_W-1:0]        instr_b,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(DEPTH - FULL_MARGIN);

  logic             wrreg_q;
  logic [CNT_W-1:0] count_q, count_d, mem_cnt;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d, wrfull_q, wrfull_d, overflow_q, overflow_d;
  logic             push_req, push, pop, load, byp, mem_re, mem_we;
  instr_t           wdata, head;

  assign wdata = '{b: data_b, a: data_a};

  always_comb begin
    push_req = wrreg & ~wrreg_q;
    pop      = valid_q & instr_ready;
    // A pop frees a slot on the same edge, so a full FIFO still accepts.
    push     = push_req & ((count_q < DEPTH_C) | pop);
    mem_cnt  = count_q - CNT_W'(valid_q);
    load     = ~valid_q | pop;
    // Nothing queued behind the head: the new word goes straight to the output.
    byp      = load & push & (mem_cnt == '0);
    mem_re   = load & (mem_cnt != '0);
    mem_we   = push & ~byp;
    wr_ptr_d = wr_ptr_q + PTR_W'(mem_we);
    rd_ptr_d = rd_ptr_q + PTR_W'(mem_re);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d  = count_d != '0;
    wrfull_d = count_d >= FULL_TH;
    overflow_d = (push_req & ~push) | (overflow_q & ~ovf_clr);
  end

  // wrreg_q resets high so a strobe held through reset is not seen as an edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wrreg_q    <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      wrfull_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrreg_q    <= wrreg;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      wrfull_q   <= wrfull_d;
      overflow_q <= overflow_d;
    end
  end

  gpu_instr_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .gclk     (clk_clk),
    .grst_n   (reset_reset_n),
    .we       (mem_we),
    .waddr    (wr_ptr_q),
    .wdata    (wdata),
    .re       (mem_re),
    .raddr    (rd_ptr_q),
    .byp      (byp),
    .byp_data (wdata),
    .rdata    (head)
  );

  assign instr_valid = valid_q;
  assign instr_a     = head.a;
  assign instr_b     = head.b;
  assign wrfull      = wrfull_q;
  assign overflow    = overflow_q;
  assign level       = count_q;

endmodule

// File: tb/tb_gpu_instr_fifo_rx.sv
// Directed bench for gpu_instr_fifo_rx: one task per scenario, inline checks.
module tb_gpu_instr_fifo_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        wrreg = 1'b0, instr_ready = 1'b0, ovf_clr = 1'b0;
  logic        wrfull, instr_valid, overflow;
  logic [31:0] instr_a, instr_b;
  logic [4:0]  level;
  int checks = 0, failures = 0;

  gpu_instr_fifo_rx #(.DEPTH(16), .FULL_MARGIN(1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .data_a(data_a), .data_b(data_b),
    .wrreg(wrreg), .wrfull(wrfull), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_a(instr_a), .instr_b(instr_b),
    .overflow(overflow), .ovf_clr(ovf_clr), .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wrreg = 1'b0; instr_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    data_a = a; data_b = b; wrreg = 1'b1;
    tick();
    wrreg = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wrreg = 1'b0; #2;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({instr_b, instr_a} !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {instr_b, instr_a}); end
    checks++; if ({wrfull, overflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {wrfull, overflow}); end
  endtask

  task automatic test_single_write();
    do_reset();
    data_a = 32'h0000_0011; data_b = 32'hCAFE_0001;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%b exp=0", instr_valid); end
    wrreg = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", instr_valid); end
    checks++; if (instr_a !== 32'h0000_0011) begin failures++; $display("FAIL single_a got=%h exp=00000011", instr_a); end
    checks++; if (instr_b !== 32'hCAFE_0001) begin failures++; $display("FAIL single_b got=%h exp=cafe0001", instr_b); end
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL single_held_level got=%0d exp=1", level); end
    wrreg = 1'b0;
    tick();
  endtask

  task automatic test_fill_and_ovf();
    do_reset();
    for (int i = 0; i < 14; i++) pulse(32'(i), 32'(i) ^ 32'hFFFF_0000);
    checks++; if (wrfull !== 1'b0) begin failures++; $display("FAIL fill14_wrfull got=%b exp=0", wrfull); end
    pulse(32'd14, 32'd14 ^ 32'hFFFF_0000);
    checks++; if (wrfull !== 1'b1) begin failures++; $display("FAIL fill15_wrfull got=%b exp=1", wrfull); end
    pulse(32'd15, 32'd15 ^ 32'hFFFF_0000);
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL fill16_level got=%0d exp=16", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill16_ovf got=%b exp=0", overflow); end
    pulse(32'hDEAD, 32'hBEEF);
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL fill17_level got=%0d exp=16", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill17_ovf got=%b exp=1", overflow); end
    checks++; if (instr_a !== 32'd0 || instr_b !== 32'hFFFF_0000) begin failures++; $display("FAIL fill17_head got=%h exp=ffff000000000000", {instr_b, instr_a}); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    data_a = 32'hBAD; wrreg = 1'b1; ovf_clr = 1'b1;
    tick();
    wrreg = 1'b0; ovf_clr = 1'b0;
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    // Push and pop on the same edge while full: nothing dropped, level holds.
    data_a = 32'h100; data_b = 32'h5100; wrreg = 1'b1; instr_ready = 1'b1;
    tick();
    wrreg = 1'b0; instr_ready = 1'b0;
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_pp_level got=%0d exp=16", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_pp_ovf got=%b exp=0", overflow); end
    checks++; if (instr_a !== 32'd1) begin failures++; $display("FAIL full_pp_head got=%h exp=1", instr_a); end
    tick();
    instr_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] exp_a;
      exp_a = (k < 15) ? 32'(k + 1) : 32'h100;
      checks++; if (instr_valid !== 1'b1 || instr_a !== exp_a) begin failures++; $display("FAIL full_pp_drain[%0d] got=%b/%h exp=1/%h", k, instr_valid, instr_a, exp_a); end
      tick();
    end
    checks++; if (instr_valid !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL full_pp_empty got=%b/%0d exp=0/0", instr_valid, level); end
    instr_ready = 1'b0;
  endtask

  task automatic test_drain_order();
    do_reset();
    for (int i = 0; i < 16; i++) pulse(32'(i), 32'h7700 + 32'(i));
    instr_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (instr_valid !== 1'b1 || instr_a !== 32'(k) || instr_b !== 32'h7700 + 32'(k)) begin failures++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", k, instr_valid, instr_a, k); end
      tick();
    end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", instr_valid); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
    checks++; if (wrfull !== 1'b0) begin failures++; $display("FAIL drain_wrfull got=%b exp=0", wrfull); end
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(32'hA1, 32'hB1);
    data_a = 32'hA2; data_b = 32'hB2; wrreg = 1'b1; instr_ready = 1'b1;
    tick();
    wrreg = 1'b0; instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", instr_valid); end
    checks++; if ({instr_b, instr_a} !== {32'hB2, 32'hA2}) begin failures++; $display("FAIL b2b_data got=%h exp=000000b2000000a2", {instr_b, instr_a}); end
    checks++; if (level !== 5'd1 || overflow !== 1'b0) begin failures++; $display("FAIL b2b_level got=%0d/%b exp=1/0", level, overflow); end
    tick();
    checks++; if (instr_a !== 32'hA2 || level !== 5'd1) begin failures++; $display("FAIL b2b_hold got=%h/%0d exp=a2/1", instr_a, level); end
  endtask

  task automatic test_backpressure();
    logic [39:0] pat;
    logic [63:0] q[$];
    logic        prev_w, exp_push, exp_pop;
    pat = 40'hB5_3C_96_E1_7A;
    do_reset();
    prev_w = 1'b0;
    for (int c = 0; c < 56; c++) begin
      wrreg = (c < 40) ? pat[c] : 1'b0;
      instr_ready = (c % 2 == 0);
      data_a = 32'h200 + 32'(c); data_b = 32'h9000 + 32'(c);
      exp_push = wrreg & ~prev_w;
      exp_pop  = (q.size() != 0) & instr_ready;
      tick();
      if (exp_pop) void'(q.pop_front());
      if (exp_push) q.push_back({data_b, data_a});
      prev_w = wrreg;
      checks++; if (level !== 5'(q.size()) || instr_valid !== (q.size() != 0)) begin failures++; $display("FAIL bp_level[%0d] got=%0d/%b exp=%0d", c, level, instr_valid, q.size()); end
      if (q.size() != 0) begin
        checks++; if ({instr_b, instr_a} !== q[0]) begin failures++; $display("FAIL bp_head[%0d] got=%h exp=%h", c, {instr_b, instr_a}, q[0]); end
      end
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL bp_residue got=%0d exp=0", q.size()); end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) pulse(32'h300 + 32'(i), 32'h0);
    checks++; if (level !== 5'd7) begin failures++; $display("FAIL mid_level7 got=%0d exp=7", level); end
    wrreg = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL mid_async got=%b/%0d exp=0/0", instr_valid, level); end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (instr_valid !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL mid_nopush got=%b/%0d exp=0/0", instr_valid, level); end
    checks++; if ({wrfull, overflow} !== 2'b00) begin failures++; $display("FAIL mid_flags got=%b exp=00", {wrfull, overflow}); end
    wrreg = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_and_ovf();
    test_drain_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
